// File: rtl/blitter_pkg.sv
// Shared blitter constants: command opcodes, framebuffer geometry, FSM state type.
package blitter_pkg;

    localparam logic [2:0] BLIT_OP_NOP       = 3'd0;
    localparam logic [2:0] BLIT_OP_CLEAR     = 3'd1;
    localparam logic [2:0] BLIT_OP_SPRITE    = 3'd2;
    localparam logic [2:0] BLIT_OP_SPRITE_16 = 3'd3;

    localparam int unsigned FB_STRIDE  = 16;
    localparam int unsigned FB_HI_ROWS = 64;
    localparam int unsigned FB_LO_ROWS = 32;
    localparam int unsigned FB_HI_COLS = 16;
    localparam int unsigned FB_LO_COLS = 8;

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StSrcRd0,
        StSrcRd1,
        StSrcLatch,
        StFbRd,
        StFbWait,
        StFbWr,
        StNextRow,
        StDone,
        StRelease
    } blit_state_e;

    // Byte k of the 24-bit row mask, leftmost byte first.
    function automatic logic [7:0] mask_byte(input logic [23:0] mask, input logic [1:0] k);
        case (k)
            2'd0:    return mask[23:16];
            2'd1:    return mask[15:8];
            default: return mask[7:0];
        endcase
    endfunction

endpackage

// File: rtl/blitter_sprite_shifter.sv
// Places one sprite row MSB-first and shifts it right by the sub-byte X offset.
module blitter_sprite_shifter (
    input  logic [7:0]  spr_hi,
    input  logic [7:0]  spr_lo,
    input  logic [2:0]  shift,
    input  logic        wide,
    output logic [23:0] mask
);

    always_comb begin
        if (wide) begin
            mask = {spr_hi, spr_lo, 8'h00} >> shift;
        end else begin
            mask = {spr_hi, 16'h0000} >> shift;
        end
    end

endmodule

// File: rtl/blitter.sv
// CHIP-8 blitter: framebuffer CLEAR and XOR sprite draws with collision detect.
// Define BLIT_WRAP_EN to wrap sprites around the screen edges instead of clipping.
module blitter
    import blitter_pkg::*;
#(
    parameter int unsigned FB_AW        = 10,
    parameter bit          CLIP_COLLIDE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hires,
    input  logic [2:0]       blit_op,
    input  logic [11:0]      blit_src,
    input  logic [3:0]       blit_srcHeight,
    input  logic [6:0]       blit_destX,
    input  logic [5:0]       blit_destY,
    input  logic             blit_enable,
    output logic             blit_done,
    output logic             blit_collision,
    output logic             blit_busy,
    output logic             spr_en,
    output logic [11:0]      spr_addr,
    input  logic [7:0]       spr_data,
    output logic             fb_en,
    output logic             fb_wr,
    output logic [FB_AW-1:0] fb_addr,
    output logic [7:0]       fb_din,
    input  logic [7:0]       fb_dout
);

`ifdef BLIT_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    blit_state_e state_q, state_d;

    logic [2:0]       op_q;
    logic [11:0]      src_q;
    logic [3:0]       height_q;
    logic [6:0]       x0_q;
    logic [5:0]       y0_q;
    logic             hires_q;
    logic [3:0]       row_q;
    logic [1:0]       byte_q;
    logic [7:0]       spr0_q, spr1_q, old_q;
    logic [FB_AW-1:0] clr_q;
    logic             collision_q;

    logic             wide;
    logic [1:0]       n_bytes;
    logic [4:0]       h_rows, row_nxt, col_lim;
    logic [6:0]       y_nxt_sum, row_lim;
    logic [1:0]       byte_nxt;
    logic [3:0]       col_ok, col_raw, col_cur;
    logic [5:0]       y_raw, y_cur;
    logic             byte_more, row_more, clip_hit;
    logic [23:0]      mask;
    logic [7:0]       mask_sel;
    logic [11:0]      spr_row_addr;
    logic [FB_AW-1:0] cur_addr;

    blitter_sprite_shifter u_shifter (
        .spr_hi(spr0_q),
        .spr_lo(spr1_q),
        .shift (x0_q[2:0]),
        .wide  (wide),
        .mask  (mask)
    );

    assign wide         = (op_q == BLIT_OP_SPRITE_16);
    assign n_bytes      = wide ? 2'd3 : 2'd2;
    assign h_rows       = wide ? 5'd16 : {1'b0, height_q};
    assign col_lim      = hires_q ? 5'(FB_HI_COLS) : 5'(FB_LO_COLS);
    assign row_lim      = hires_q ? 7'(FB_HI_ROWS) : 7'(FB_LO_ROWS);
    assign row_nxt      = {1'b0, row_q} + 5'd1;
    assign y_nxt_sum    = {1'b0, y0_q} + {2'b00, row_nxt};
    assign byte_nxt     = byte_q + 2'd1;
    assign mask_sel     = mask_byte(mask, byte_q);
    assign spr_row_addr = wide ? src_q + {7'd0, row_q, 1'b0} : src_q + {8'd0, row_q};

    // Coordinates wrap modulo the active screen size; when clipping, drawn bytes never wrap.
    assign col_raw  = x0_q[6:3] + {2'b00, byte_q};
    assign col_cur  = hires_q ? col_raw : {1'b0, col_raw[2:0]};
    assign y_raw    = y0_q + {2'b00, row_q};
    assign y_cur    = hires_q ? y_raw : {1'b0, y_raw[4:0]};
    assign cur_addr = FB_AW'(32'(y_cur) * FB_STRIDE + 32'(col_cur));

    always_comb begin
        col_ok   = '0;
        clip_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            col_ok[k] = WrapEn || (({1'b0, x0_q[6:3]} + 5'(k)) < col_lim);
        end
        for (int k = 0; k < 3; k++) begin
            if ((2'(k) < n_bytes) && !col_ok[k] && (mask_byte(mask, 2'(k)) != 8'h00)) begin
                clip_hit = 1'b1;
            end
        end
    end

    assign byte_more = (byte_nxt < n_bytes) && col_ok[byte_nxt];
    assign row_more  = (row_nxt < h_rows) && (WrapEn || (y_nxt_sum < row_lim));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (blit_enable) begin
                    case (blit_op)
                        BLIT_OP_CLEAR:     state_d = StClear;
                        BLIT_OP_SPRITE:    state_d = (blit_srcHeight != 4'd0) ? StSrcRd0 : StDone;
                        BLIT_OP_SPRITE_16: state_d = StSrcRd0;
                        default:           state_d = StDone;
                    endcase
                end
            end
            StClear:    if (clr_q == '1) state_d = StIdle;
            StSrcRd0:   state_d = StSrcRd1;
            StSrcRd1:   state_d = StSrcLatch;
            StSrcLatch: state_d = StFbRd;
            StFbRd:     state_d = StFbWait;
            StFbWait:   state_d = StFbWr;
            StFbWr:     state_d = byte_more ? StFbRd : StNextRow;
            StNextRow:  state_d = row_more ? StSrcRd0 : StDone;
            StDone:     state_d = StRelease;
            StRelease:  if (!blit_enable) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= BLIT_OP_NOP;
            src_q       <= '0;
            height_q    <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            hires_q     <= 1'b0;
            row_q       <= '0;
            byte_q      <= '0;
            spr0_q      <= '0;
            spr1_q      <= '0;
            old_q       <= '0;
            clr_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (blit_enable) begin
                        op_q     <= blit_op;
                        src_q    <= blit_src;
                        height_q <= blit_srcHeight;
                        hires_q  <= hires;
                        x0_q     <= hires ? blit_destX : {1'b0, blit_destX[5:0]};
                        y0_q     <= hires ? blit_destY : {1'b0, blit_destY[4:0]};
                        row_q    <= '0;
                        clr_q    <= '0;
                        if (blit_op != BLIT_OP_CLEAR) collision_q <= 1'b0;
                    end
                end
                StClear:    clr_q <= clr_q + 1'b1;
                StSrcRd1:   spr0_q <= spr_data;
                StSrcLatch: begin
                    spr1_q <= wide ? spr_data : 8'h00;
                    byte_q <= '0;
                end
                StFbWait: begin
                    old_q <= fb_dout;
                    if ((fb_dout & mask_sel) != 8'h00) collision_q <= 1'b1;
                end
                StFbWr:     byte_q <= byte_nxt;
                StNextRow: begin
                    row_q <= row_nxt[3:0];
                    // Optionally count pixels that fell off the right edge as hits.
                    if (!CLIP_COLLIDE && clip_hit) collision_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        blit_done      = (state_q == StDone);
        blit_busy      = (state_q != StIdle);
        blit_collision = collision_q;
        spr_en         = 1'b0;
        spr_addr       = '0;
        fb_en          = 1'b0;
        fb_wr          = 1'b0;
        fb_addr        = '0;
        fb_din         = '0;
        case (state_q)
            StClear: begin
                fb_en   = 1'b1;
                fb_wr   = 1'b1;
                fb_addr = clr_q;
            end
            StSrcRd0: begin
                spr_en   = 1'b1;
                spr_addr = spr_row_addr;
            end
            StSrcRd1: begin
                spr_en   = wide;
                spr_addr = wide ? spr_row_addr + 12'd1 : 12'd0;
            end
            StFbRd: begin
                fb_en   = 1'b1;
                fb_addr = cur_addr;
            end
            StFbWr: begin
                fb_en   = 1'b1;
                fb_wr   = 1'b1;
                fb_addr = cur_addr;
                fb_din  = old_q ^ mask_sel;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_blitter.sv
// Self-checking bench for blitter: pixel-level XOR model with clip/wrap, random sprites.
module tb_blitter;

    localparam int OP_CLEAR = 1;
    localparam int OP_SPR   = 2;
    localparam int OP_SPR16 = 3;
`ifdef BLIT_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, hires, blit_enable;
    logic [2:0] blit_op;
    logic [11:0] blit_src;
    logic [3:0] blit_srcHeight;
    logic [6:0] blit_destX;
    logic [5:0] blit_destY;
    logic blit_done, blit_collision, blit_busy;
    logic spr_en, fb_en, fb_wr;
    logic [11:0] spr_addr;
    logic [7:0] spr_data, fb_din, fb_dout;
    logic [9:0] fb_addr;

    logic [7:0] mem     [4096];
    logic [7:0] fbmem   [1024];
    logic [7:0] fb_ref  [1024];
    logic [7:0] fb_init [1024];
    logic bd_load = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    blitter dut (
        .clk(clk), .reset(reset), .hires(hires), .blit_op(blit_op), .blit_src(blit_src),
        .blit_srcHeight(blit_srcHeight), .blit_destX(blit_destX), .blit_destY(blit_destY),
        .blit_enable(blit_enable), .blit_done(blit_done), .blit_collision(blit_collision),
        .blit_busy(blit_busy), .spr_en(spr_en), .spr_addr(spr_addr), .spr_data(spr_data),
        .fb_en(fb_en), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_din(fb_din), .fb_dout(fb_dout)
    );

    always @(posedge clk) if (spr_en) spr_data <= mem[spr_addr];

    always @(posedge clk) begin
        if (bd_load) begin
            for (int i = 0; i < 1024; i++) fbmem[i] <= fb_init[i];
        end else if (fb_en) begin
            if (fb_wr) fbmem[fb_addr] <= fb_din;
            else fb_dout <= fbmem[fb_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int fb_diff();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (fbmem[i] !== fb_ref[i]) n++;
        return n;
    endfunction

    task automatic load_fb(input bit zero);
        for (int i = 0; i < 1024; i++) begin
            fb_init[i] = zero ? 8'h00 : 8'($urandom);
            fb_ref[i]  = fb_init[i];
        end
        bd_load = 1'b1;
        tick();
        bd_load = 1'b0;
    endtask

    // Reference: every set sprite pixel toggles one screen pixel; off-screen pixels are
    // dropped (or wrapped), and the first off-screen row ends the sprite unless wrapping.
    task automatic model_sprite(input int op, input int src, input int h, input int x,
                                input int y, input bit hr, output bit coll);
        int w, ht, x0, y0, rows, wid, px, py, a, b;
        logic [15:0] data;
        logic [11:0] sa;
        w = hr ? 128 : 64;
        ht = hr ? 64 : 32;
        x0 = x % w;
        y0 = y % ht;
        coll = 1'b0;
        wid = (op == OP_SPR16) ? 16 : 8;
        rows = (op == OP_SPR16) ? 16 : h;
        for (int r = 0; r < rows; r++) begin
            py = y0 + r;
            if (py >= ht) begin
                if (WRAP) py = py - ht;
                else break;
            end
            if (wid == 16) begin
                sa = 12'(src + 2 * r);
                data[15:8] = mem[sa];
                sa = sa + 12'd1;
                data[7:0] = mem[sa];
            end else begin
                sa = 12'(src + r);
                data = {mem[sa], 8'h00};
            end
            for (int i = 0; i < wid; i++) begin
                if (data[15-i]) begin
                    px = x0 + i;
                    if (px >= w) begin
                        if (WRAP) px = px - w;
                        else continue;
                    end
                    a = py * 16 + px / 8;
                    b = 7 - px % 8;
                    if (fb_ref[a][b]) coll = 1'b1;
                    fb_ref[a][b] = ~fb_ref[a][b];
                end
            end
        end
    endtask

    // Issues one command. done_cyc counts cycles from the accept edge (-1 if never seen).
    task automatic run_cmd(input int op, input int src, input int h, input int x, input int y,
                           input bit hr, input bit hold, output int done_cyc,
                           output logic coll, output int done_cnt);
        blit_op = 3'(op);
        blit_src = 12'(src);
        blit_srcHeight = 4'(h);
        blit_destX = 7'(x);
        blit_destY = 6'(y);
        hires = hr;
        blit_enable = 1'b1;
        tick();
        if (!hold) blit_enable = 1'b0;
        done_cyc = -1;
        done_cnt = 0;
        coll = 1'bx;
        for (int i = 1; i < 3000; i++) begin
            if (blit_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = i;
                    coll = blit_collision;
                end
                if (hold) break;
            end
            if (!hold && blit_busy === 1'b0) break;
            tick();
        end
        if (op == OP_CLEAR) for (int i = 0; i < 1024; i++) fb_ref[i] = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (blit_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", blit_busy); else n_pass++;
        n_checks++; if (blit_done !== 1'b0) $display("FAIL reset_done got=%b want=0", blit_done); else n_pass++;
        n_checks++; if (blit_collision !== 1'b0) $display("FAIL reset_coll got=%b want=0", blit_collision); else n_pass++;
        n_checks++;
        if ({spr_en, fb_en, fb_wr} !== 3'b000)
            $display("FAIL reset_ports got=%b want=000", {spr_en, fb_en, fb_wr});
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int busy_cnt = 0, nz = 0;
        bit saw_done = 1'b0;
        load_fb(1'b0);
        blit_op = 3'(OP_CLEAR);
        blit_enable = 1'b1;
        tick();
        blit_enable = 1'b0;
        for (int i = 0; i < 3000 && blit_busy === 1'b1; i++) begin
            busy_cnt++;
            if (blit_done === 1'b1) saw_done = 1'b1;
            tick();
        end
        for (int i = 0; i < 1024; i++) if (fbmem[i] !== 8'h00) nz++;
        for (int i = 0; i < 1024; i++) fb_ref[i] = 8'h00;
        n_checks++; if (busy_cnt != 1024) $display("FAIL clear_cycles got=%0d want=1024", busy_cnt); else n_pass++;
        n_checks++; if (saw_done) $display("FAIL clear_no_done got=1 want=0"); else n_pass++;
        n_checks++; if (blit_busy !== 1'b0) $display("FAIL clear_busy_drop got=%b want=0", blit_busy); else n_pass++;
        n_checks++; if (nz != 0) $display("FAIL clear_bytes nonzero=%0d want=0", nz); else n_pass++;
    endtask

    task automatic test_sprite_basic();
        int dc, dn;
        logic c;
        bit mc;
        mem[12'h200] = 8'hF0;
        mem[12'h201] = 8'h90;
        run_cmd(OP_SPR, 12'h200, 2, 3, 0, 1'b0, 1'b0, dc, c, dn);
        model_sprite(OP_SPR, 12'h200, 2, 3, 0, 1'b0, mc);
        n_checks++; if (fbmem[0] !== 8'h1E) $display("FAIL spr_byte0 got=%h want=1e", fbmem[0]); else n_pass++;
        n_checks++; if (fbmem[1] !== 8'h00) $display("FAIL spr_byte1 got=%h want=00", fbmem[1]); else n_pass++;
        n_checks++; if (fbmem[16] !== 8'h12) $display("FAIL spr_byte16 got=%h want=12", fbmem[16]); else n_pass++;
        n_checks++; if (fbmem[17] !== 8'h00) $display("FAIL spr_byte17 got=%h want=00", fbmem[17]); else n_pass++;
        n_checks++; if (dn != 1) $display("FAIL spr_done_pulses got=%0d want=1", dn); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL spr_coll got=%b want=0", c); else n_pass++;
        n_checks++; if (dc < 1 || dc > 24) $display("FAIL spr_latency got=%0d want<=24", dc); else n_pass++;
        run_cmd(OP_SPR, 12'h200, 2, 3, 0, 1'b0, 1'b0, dc, c, dn);
        model_sprite(OP_SPR, 12'h200, 2, 3, 0, 1'b0, mc);
        n_checks++; if (c !== 1'b1) $display("FAIL redraw_coll got=%b want=1", c); else n_pass++;
        n_checks++;
        if (fbmem[0] !== 8'h00 || fbmem[16] !== 8'h00)
            $display("FAIL redraw_erase got=%h,%h want=00,00", fbmem[0], fbmem[16]);
        else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL redraw_fb diffs=%0d want=0", fb_diff()); else n_pass++;
    endtask

    task automatic test_unknown_op();
        int dc, dn;
        logic c;
        for (int op = 4; op < 8; op += 3) begin
            run_cmd(op, 0, 1, 0, 0, 1'b0, 1'b0, dc, c, dn);
            n_checks++; if (dn != 1) $display("FAIL unk_done op=%0d got=%0d want=1", op, dn); else n_pass++;
            n_checks++; if (c !== 1'b0) $display("FAIL unk_coll op=%0d got=%b want=0", op, c); else n_pass++;
        end
        n_checks++; if (fb_diff() != 0) $display("FAIL unk_fb diffs=%0d want=0", fb_diff()); else n_pass++;
    endtask

    task automatic test_clip();
        int dc, dn;
        logic c;
        bit mc;
        run_cmd(OP_CLEAR, 0, 0, 0, 0, 1'b0, 1'b0, dc, c, dn);
        for (int i = 0; i < 4; i++) mem[12'h300 + i] = 8'hFF;
        run_cmd(OP_SPR, 12'h300, 4, 62, 31, 1'b0, 1'b0, dc, c, dn);
        model_sprite(OP_SPR, 12'h300, 4, 62, 31, 1'b0, mc);
        n_checks++; if (fbmem[503] !== 8'h03) $display("FAIL clip_edge got=%h want=03", fbmem[503]); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL clip_coll got=%b want=0", c); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL clip_fb diffs=%0d want=0", fb_diff()); else n_pass++;
        n_checks++; if (dc < 1 || dc > 44) $display("FAIL clip_latency got=%0d want<=44", dc); else n_pass++;
    endtask

    task automatic test_hires16();
        int dc, dn;
        logic c;
        bit mc;
        run_cmd(OP_CLEAR, 0, 0, 0, 0, 1'b1, 1'b0, dc, c, dn);
        for (int i = 0; i < 32; i++) mem[12'h400 + i] = 8'hFF;
        run_cmd(OP_SPR16, 12'h400, 0, 120, 0, 1'b1, 1'b0, dc, c, dn);
        model_sprite(OP_SPR16, 12'h400, 0, 120, 0, 1'b1, mc);
        n_checks++; if (fbmem[15] !== 8'hFF) $display("FAIL h16_row0 got=%h want=ff", fbmem[15]); else n_pass++;
        n_checks++; if (fbmem[255] !== 8'hFF) $display("FAIL h16_row15 got=%h want=ff", fbmem[255]); else n_pass++;
        n_checks++; if (dc < 1 || dc > 228) $display("FAIL h16_latency got=%0d want<=228", dc); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL h16_fb diffs=%0d want=0", fb_diff()); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL h16_coll got=%b want=0", c); else n_pass++;
    endtask

    task automatic test_random();
        int dc, dn, op, src, h, x, y, lim;
        bit hr, mc;
        logic c;
        load_fb(1'b0);
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(OP_SPR16, OP_SPR);
            hr = 1'($urandom);
            src = $urandom_range(4095, 0);
            h = $urandom_range(15, 1);
            x = $urandom_range(127, 0);
            y = $urandom_range(63, 0);
            run_cmd(op, src, h, x, y, hr, 1'b0, dc, c, dn);
            model_sprite(op, src, h, x, y, hr, mc);
            lim = (op == OP_SPR16) ? 228 : 10 * h + 4;
            n_checks++;
            if (c !== mc) $display("FAIL rnd_coll it=%0d got=%b want=%b", it, c, mc); else n_pass++;
            n_checks++;
            if (fb_diff() != 0) $display("FAIL rnd_fb it=%0d diffs=%0d want=0", it, fb_diff()); else n_pass++;
            n_checks++;
            if (dc < 1 || dc > lim) $display("FAIL rnd_latency it=%0d got=%0d want<=%0d", it, dc, lim);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, extra = 0;
        logic c;
        bit mc, dropped = 1'b0;
        run_cmd(OP_SPR, 12'h123, 5, 17, 9, 1'b0, 1'b1, dc, c, dn);
        model_sprite(OP_SPR, 12'h123, 5, 17, 9, 1'b0, mc);
        n_checks++; if (c !== mc) $display("FAIL hold_coll got=%b want=%b", c, mc); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (blit_done === 1'b1) extra++;
            if (blit_busy !== 1'b1) dropped = 1'b1;
        end
        n_checks++; if (extra != 0) $display("FAIL hold_retrigger got=%0d want=0", extra); else n_pass++;
        n_checks++; if (dropped) $display("FAIL hold_busy got=0 want=1"); else n_pass++;
        blit_enable = 1'b0;
        tick();
        n_checks++; if (blit_busy !== 1'b0) $display("FAIL release_idle got=%b want=0", blit_busy); else n_pass++;
        run_cmd(OP_SPR16, 12'h0F0, 0, 70, 50, 1'b1, 1'b0, dc, c, dn);
        model_sprite(OP_SPR16, 12'h0F0, 0, 70, 50, 1'b1, mc);
        n_checks++; if (c !== mc) $display("FAIL b2b_coll got=%b want=%b", c, mc); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL b2b_fb diffs=%0d want=0", fb_diff()); else n_pass++;
    endtask

    task automatic test_enable_during_clear();
        int done_at = -1;
        logic c = 1'bx;
        bit mc;
        blit_op = 3'(OP_CLEAR);
        blit_enable = 1'b1;
        tick();
        blit_op = 3'(OP_SPR);
        blit_src = 12'h200;
        blit_srcHeight = 4'd2;
        blit_destX = 7'd40;
        blit_destY = 6'd20;
        hires = 1'b0;
        for (int i = 1; i < 3000; i++) begin
            if (blit_done === 1'b1) begin
                done_at = i;
                c = blit_collision;
                break;
            end
            tick();
        end
        blit_enable = 1'b0;
        for (int i = 0; i < 10 && blit_busy === 1'b1; i++) tick();
        for (int i = 0; i < 1024; i++) fb_ref[i] = 8'h00;
        model_sprite(OP_SPR, 12'h200, 2, 40, 20, 1'b0, mc);
        n_checks++; if (done_at <= 1024) $display("FAIL queued_after_clear done_at=%0d want>1024", done_at); else n_pass++;
        n_checks++; if (c !== mc) $display("FAIL queued_coll got=%b want=%b", c, mc); else n_pass++;
        n_checks++; if (blit_busy !== 1'b0) $display("FAIL queued_idle got=%b want=0", blit_busy); else n_pass++;
        n_checks++; if (fb_diff() != 0) $display("FAIL queued_fb diffs=%0d want=0", fb_diff()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dn = 0, dc, dd;
        logic c;
        bit mc, bad_busy = 1'b0;
        blit_op = 3'(OP_SPR16);
        blit_src = 12'h400;
        blit_destX = 7'd8;
        blit_destY = 6'd8;
        hires = 1'b1;
        blit_enable = 1'b1;
        tick();
        blit_enable = 1'b0;
        repeat (30) tick();
        n_checks++; if (blit_busy !== 1'b1) $display("FAIL mid_busy got=%b want=1", blit_busy); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({blit_busy, blit_done, blit_collision, spr_en, fb_en} !== 5'b0)
            $display("FAIL mid_reset_outs got=%b want=00000",
                     {blit_busy, blit_done, blit_collision, spr_en, fb_en});
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (blit_done === 1'b1) dn++;
            if (blit_busy !== 1'b0) bad_busy = 1'b1;
        end
        n_checks++; if (dn != 0 || bad_busy) $display("FAIL mid_no_done done=%0d busy=%b want=0,0", dn, bad_busy); else n_pass++;
        load_fb(1'b0);
        run_cmd(OP_SPR, 12'h300, 3, 5, 5, 1'b0, 1'b0, dc, c, dd);
        model_sprite(OP_SPR, 12'h300, 3, 5, 5, 1'b0, mc);
        n_checks++; if (fb_diff() != 0 || c !== mc) $display("FAIL post_reset diffs=%0d coll=%b want=0,%b", fb_diff(), c, mc); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        hires = 1'b0;
        blit_enable = 1'b0;
        blit_op = '0;
        blit_src = '0;
        blit_srcHeight = '0;
        blit_destX = '0;
        blit_destY = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        test_reset();
        test_clear();
        test_sprite_basic();
        test_unknown_op();
        test_clip();
        test_hires16();
        test_random();
        test_back_to_back();
        test_enable_during_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/blitter.md
Name: blitter

Overview:
- Downstream consumer of the CHIP-8 CPU's blit command interface (blit_op/src/srcHeight/destX/destY/enable).
- Executes framebuffer CLEAR and XOR sprite draws (8xN, 16x16), reports completion and collision back to the CPU.
- Reads sprite bytes through a dedicated read port of main RAM; read-modify-writes a byte-wide 128x64 framebuffer RAM that video scanout also reads.

Parameters:
- FB_AW, 10, framebuffer byte address width (128x64 bits, stride 16 bytes/row).
- CLIP_COLLIDE, 1, if 1 collision counts only pixels actually drawn (after clip/wrap).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hires  in  1  CPU mode; sampled at command accept.
- blit_op  in  3  command (BLIT_OP_*).
- blit_src  in  12  sprite base address in main RAM.
- blit_srcHeight  in  4  rows for BLIT_OP_SPRITE (1..15).
- blit_destX  in  7  sprite X.
- blit_destY  in  6  sprite Y.
- blit_enable  in  1  command request level.
- blit_done  out  1  one-cycle pulse at sprite completion.
- blit_collision  out  1  collision result, valid from blit_done onward.
- blit_busy  out  1  high from accept until return to IDLE.
- spr_en / spr_addr  out  1/12  main-RAM read request/address, 1-cycle read latency.
- spr_data  in  8  sprite byte.
- fb_en / fb_wr / fb_addr / fb_din  out  1/1/FB_AW/8  framebuffer port, 1-cycle read latency.
- fb_dout  in  8  framebuffer read data.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-command: abort next edge, no done pulse, framebuffer left partially written.
- Accept: in IDLE with blit_enable=1 -> latch op, src, height, X, Y, hires; blit_busy=1 next cycle. blit_enable ignored while not IDLE. A held request is taken when IDLE is reached.
- States: IDLE, CLEAR, SRC_RD0, SRC_RD1, SRC_LATCH, FB_RD, FB_WAIT, FB_WR, NEXT_ROW, DONE, RELEASE.
- CLEAR: write 0 to addresses 0..1023, one per cycle, 1024 cycles, then IDLE. No blit_done pulse; collision unchanged.
- Geometry: W=128,H=64 if hires, else W=64,H=32 (top-left of buffer). Start x0=destX mod W, y0=destY mod H. fb_addr = y*16 + (x>>3).
- SPRITE: rows r=0..h-1. SPRITE_16: h=16, two bytes per row at src+2r and src+2r+1. SPRITE row data at src+r.
- Row shift: sprite bits are placed MSB-first and shifted right by x0[2:0] into a 16-bit (8-wide) or 24-bit (16-wide) mask. The mask spans 2 or 3 fb bytes starting at byte x0>>3.
- Clip: rows with y0+r >= H are skipped and terminate the sprite. Bytes with (x0>>3)+k >= W/8 are skipped. Fully-zero mask bytes may still be written.
- Per fb byte: read old, write old^mask. Set collision if (old & mask) != 0.
- Collision is cleared at accept of a sprite command.
- Timing: each fb byte takes 3 cycles. 8xN completes in <= 10N+4 cycles; 16x16 in <= 228 cycles.
- DONE: blit_done=1 for exactly one cycle, then RELEASE until blit_enable=0, then IDLE. This stops a still-asserted request from re-triggering.
- Unknown op: go straight to DONE with collision=0.

Optional Feature:
- BLIT_WRAP_EN defined: no clipping. Rows wrap (y0+r) mod H; bytes wrap ((x0>>3)+k) mod (W/8). All rows are drawn.
- BLIT_WRAP_EN undefined: clipping as above.

Decomposition:
- blitter.vh holds BLIT_OP_NOP=0, BLIT_OP_CLEAR=1, BLIT_OP_SPRITE=2, BLIT_OP_SPRITE_16=3, plus FB stride/dims constants.
- One sub-module, sprite_shifter: combinational; inputs sprite bytes, x0[2:0], wide flag; output 24-bit mask.

Test Plan:
- CLEAR on a pre-filled FB -> all 1024 bytes 0 after 1024 cycles; no blit_done pulse; busy drops.
- SPRITE, src bytes F0,90, h=2, X=3, Y=0, lowres -> byte0=1E, byte1=00, byte16=12, byte17=00; done pulse; collision=0.
- Redraw the same sprite -> region returns to 0; collision=1.
- Lowres SPRITE at X=62, Y=31, h=4, bytes FF -> only addr 7*16... row31 byte7 = 03; rows beyond clipped. With BLIT_WRAP_EN, bytes wrap to byte0/row0.
- Hires SPRITE_16 at X=120, Y=0, all FF -> bytes 15 of rows 0..15 = FF, nothing at byte0; done <= 228 cycles.
- Sprite enable asserted during CLEAR, reset pulse mid-sprite -> sprite starts only after CLEAR; reset returns IDLE, all outputs 0, no done.
